// File: rtl/histogram_cdf_builder.sv
// Histogram CDF builder: sweeps scratch bin counts into a saturating
// running sum and writes each CDF value to the equalization LUT.
// Optional CDF_CLEAR_BINS_EN: zero each scratch bin as it is consumed.
module histogram_cdf_builder #(
    parameter int NUM_BINS     = 256,
    parameter int BIN_ADDR_W   = 8,
    parameter int COUNT_W      = 16,
    parameter int CDF_W        = 18,
    parameter int READ_LATENCY = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_cdf,
    output logic [BIN_ADDR_W-1:0] scratch_read_address,
    output logic                  scratch_read_enable,
    input  logic [COUNT_W-1:0]    scratch_read_data,
    output logic [BIN_ADDR_W-1:0] scratch_write_address,
    output logic                  scratch_write_enable,
    output logic [COUNT_W-1:0]    scratch_write_data,
    output logic [BIN_ADDR_W-1:0] lut_write_address,
    output logic                  lut_write_enable,
    output logic [CDF_W-1:0]      lut_write_data,
    output logic                  cdf_busy,
    output logic                  cdf_done,
    output logic [CDF_W-1:0]      total_count
);

    localparam int WCNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST =
        WCNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
    localparam logic [CDF_W-1:0] ACC_MAX = '1;
    localparam logic [BIN_ADDR_W-1:0] LAST_BIN = BIN_ADDR_W'(NUM_BINS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_CAPTURE,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [BIN_ADDR_W-1:0] bin_idx_q, bin_idx_d;
    logic [CDF_W-1:0]      acc_q, acc_d;
    logic [CDF_W-1:0]      total_q, total_d;
    logic [WCNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  rd_en_q, rd_en_d;
    logic                  lut_we_q, lut_we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [CDF_W:0]        sum;

    assign sum = {1'b0, acc_q}
               + {{(CDF_W + 1 - COUNT_W){1'b0}}, scratch_read_data};

    // Next-state, datapath and registered Moore strobes for the sweep.
    always_comb begin
        state_d    = state_q;
        bin_idx_d  = bin_idx_q;
        acc_d      = acc_q;
        total_d    = total_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_cdf) begin
                    acc_d     = '0;
                    bin_idx_d = '0;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                wait_cnt_d = '0;
                state_d    = (READ_LATENCY == 1) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                acc_d   = sum[CDF_W] ? ACC_MAX : sum[CDF_W-1:0];
                state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (bin_idx_q == LAST_BIN) begin
                    state_d = S_DONE;
                end else begin
                    bin_idx_d = bin_idx_q + 1'b1;
                    state_d   = S_ADDR;
                end
            end
            S_DONE: begin
                total_d = acc_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        rd_en_d  = (state_d == S_ADDR);
        lut_we_d = (state_d == S_WRITE);
        done_d   = (state_d == S_DONE);
        busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bin_idx_q  <= '0;
            acc_q      <= '0;
            total_q    <= '0;
            wait_cnt_q <= '0;
            rd_en_q    <= 1'b0;
            lut_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_idx_q  <= bin_idx_d;
            acc_q      <= acc_d;
            total_q    <= total_d;
            wait_cnt_q <= wait_cnt_d;
            rd_en_q    <= rd_en_d;
            lut_we_q   <= lut_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign scratch_read_address = bin_idx_q;
    assign scratch_read_enable  = rd_en_q;
    assign lut_write_address    = bin_idx_q;
    assign lut_write_enable     = lut_we_q;
    assign lut_write_data       = acc_q;
    assign cdf_busy             = busy_q;
    assign cdf_done             = done_q;
    assign total_count          = total_q;
    assign scratch_write_data   = '0;

`ifdef CDF_CLEAR_BINS_EN
    logic scr_we_q;

    // Clear each scratch bin in the same cycle its CDF value is written.
    always_ff @(posedge clock) begin
        if (reset) begin
            scr_we_q <= 1'b0;
        end else begin
            scr_we_q <= lut_we_d;
        end
    end

    assign scratch_write_enable  = scr_we_q;
    assign scratch_write_address = bin_idx_q;
`else
    assign scratch_write_enable  = 1'b0;
    assign scratch_write_address = '0;
`endif

endmodule

// File: tb/tb_histogram_cdf_builder.sv
// Randomized bench for histogram_cdf_builder against a prefix-sum model
// with a modelled scratch memory of fixed read latency.
module tb_histogram_cdf_builder;

    localparam int NB  = 256;
    localparam int AW  = 8;
    localparam int CW  = 16;
    localparam int DW  = 18;
    localparam int RL  = 3;
    localparam longint MAXV = (64'd1 << DW) - 1;
    localparam int DONE_CYC = NB * (RL + 3) + 1;

    logic          clock;
    logic          reset;
    logic          start_cdf;
    logic [AW-1:0] scr_ra;
    logic          scr_re;
    logic [CW-1:0] scr_rd;
    logic [AW-1:0] scr_wa;
    logic          scr_we;
    logic [CW-1:0] scr_wd;
    logic [AW-1:0] lut_wa;
    logic          lut_we;
    logic [DW-1:0] lut_wd;
    logic          busy;
    logic          done;
    logic [DW-1:0] total;

    histogram_cdf_builder #(
        .NUM_BINS    (NB),
        .BIN_ADDR_W  (AW),
        .COUNT_W     (CW),
        .CDF_W       (DW),
        .READ_LATENCY(RL)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .start_cdf            (start_cdf),
        .scratch_read_address (scr_ra),
        .scratch_read_enable  (scr_re),
        .scratch_read_data    (scr_rd),
        .scratch_write_address(scr_wa),
        .scratch_write_enable (scr_we),
        .scratch_write_data   (scr_wd),
        .lut_write_address    (lut_wa),
        .lut_write_enable     (lut_we),
        .lut_write_data       (lut_wd),
        .cdf_busy             (busy),
        .cdf_done             (done),
        .total_count          (total)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [CW-1:0] mem [NB];
    logic [CW-1:0] orig [NB];
    logic [DW-1:0] lut_got [NB];
    longint        exp_cdf [NB];
    logic [CW-1:0] pipe [RL];
    int lut_cnt, scr_cnt, done_cnt, bad_addr;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scratch memory read port: data appears RL cycles after the strobe.
    always @(posedge clock) begin
        pipe[0] <= scr_re ? mem[scr_ra] : '0;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign scr_rd = pipe[RL-1];

    // Capture LUT writes, scratch writes and done pulses mid-cycle.
    always @(negedge clock) begin
        if (lut_we) begin
            lut_got[lut_wa] = lut_wd;
            lut_cnt++;
        end
        if (scr_we) begin
            mem[scr_wa] = scr_wd;
            scr_cnt++;
        end
        if (scr_re && int'(scr_ra) >= NB) bad_addr++;
        if (done) done_cnt++;
    end

    task automatic load(input int mode);
        for (int k = 0; k < NB; k++) begin
            case (mode)
                0: mem[k] = 16'd1;
                1: mem[k] = (k == 0) ? 16'hFFFF : 16'd0;
                2: mem[k] = CW'($urandom_range(0, 1000));
                3: mem[k] = CW'($urandom);
                default: mem[k] = ($urandom_range(0, 3) == 0)
                                  ? CW'($urandom_range(0, 5000)) : '0;
            endcase
        end
    endtask

    task automatic build_model();
        longint run;
        run = 0;
        for (int k = 0; k < NB; k++) begin
            orig[k] = mem[k];
            run += longint'(mem[k]);
            exp_cdf[k] = (run > MAXV) ? MAXV : run;
        end
    endtask

    task automatic clear_obs();
        lut_cnt = 0;
        scr_cnt = 0;
        done_cnt = 0;
        bad_addr = 0;
        for (int k = 0; k < NB; k++) lut_got[k] = '0;
    endtask

    task automatic sweep(input string nm, input bit extra);
        int n;
        bit seen;
        int bad, nz;
        build_model();
        clear_obs();
        @(negedge clock);
        start_cdf = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 3000) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            start_cdf = 1'b0;
            if (extra && n == 10) start_cdf = 1'b1;
            if (n == 5) chk({nm, "_busy_mid"}, busy, 1);
            if (done) begin
                seen = 1'b1;
                if (extra) start_cdf = 1'b1;
            end
        end
        chk({nm, "_done_seen"}, seen, 1);
        chk({nm, "_done_cycle"}, n, DONE_CYC);
        @(negedge clock);
        start_cdf = 1'b0;
        repeat (10) @(negedge clock);
        chk({nm, "_lut_writes"}, lut_cnt, NB);
        chk({nm, "_done_pulses"}, done_cnt, 1);
        chk({nm, "_busy_after"}, busy, 0);
        chk({nm, "_bad_addr"}, bad_addr, 0);
        chk({nm, "_total"}, total, exp_cdf[NB-1]);
        bad = 0;
        for (int k = 0; k < NB; k++) begin
            if (longint'(lut_got[k]) != exp_cdf[k]) begin
                if (bad < 4)
                    chk($sformatf("%s_lut%0d", nm, k), lut_got[k], exp_cdf[k]);
                bad++;
            end
        end
        chk({nm, "_lut_bad_bins"}, bad, 0);
        nz = 0;
`ifdef CDF_CLEAR_BINS_EN
        for (int k = 0; k < NB; k++) if (mem[k] != '0) nz++;
        chk({nm, "_scr_nonzero"}, nz, 0);
        chk({nm, "_scr_writes"}, scr_cnt, NB);
`else
        for (int k = 0; k < NB; k++) if (mem[k] != orig[k]) nz++;
        chk({nm, "_scr_changed"}, nz, 0);
        chk({nm, "_scr_writes"}, scr_cnt, 0);
`endif
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_rd_en"}, scr_re, 0);
        chk({nm, "_lut_we"}, lut_we, 0);
        chk({nm, "_scr_we"}, scr_we, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_rd_addr"}, scr_ra, 0);
        chk({nm, "_lut_addr"}, lut_wa, 0);
        chk({nm, "_lut_data"}, lut_wd, 0);
        chk({nm, "_total"}, total, 0);
    endtask

    initial begin
        reset = 1'b1;
        start_cdf = 1'b0;
        for (int i = 0; i < RL; i++) pipe[i] = '0;
        load(0);
        clear_obs();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero("reset");
        reset = 1'b0;

        load(0);
        sweep("ones", 1'b0);
        load(1);
        sweep("bin0", 1'b1);
        load(2);
        sweep("rand_small", 1'b0);
        load(3);
        sweep("rand_sat", 1'b0);

        load(4);
        clear_obs();
        @(negedge clock);
        start_cdf = 1'b1;
        repeat (50) begin
            @(posedge clock);
            @(negedge clock);
            start_cdf = 1'b0;
        end
        chk("abort_busy", busy, 1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_zero("abort");
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort_idle", busy, 0);

        load(4);
        sweep("restart", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
